bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter and address decoder for the board's shared 16-bit memory bus. It lets the CPU (master 0) and a DMA/video-fetch engine (master 1) share RAM, GPU, diodes and LED counter. It serialises their accesses, drives one slave strobe set with decoded chip selects, and returns read data plus a per-transfer acknowledge to the winning master.

## Interface
Parameters:
- `WAIT_CYCLES`, default 1: extra cycles a strobe is held beyond the first (range 0–7).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1 each  transfer request, level.
- `m0_we`, `m1_we`  in  1 each  1 = write, 0 = read.
- `m0_lock`, `m1_lock`  in  1 each  keep grant for back-to-back transfers.
- `m0_addr`, `m1_addr`  in  16 each  byte-free word address.
- `m0_wdata`, `m1_wdata`  in  16 each  write data.
- `m0_gnt`, `m1_gnt`  out  1 each  master currently owns the bus.
- `m0_ack`, `m1_ack`  out  1 each  one-cycle completion pulse.
- `m_rdata`  out  16  read data, valid only during that master's ack.
- `m_err`  out  1  unmapped address, valid with ack.
- `address_bus`  out  16  slave address.
- `wdata_bus`  out  16  slave write data.
- `rdata_bus`  in  16  slave read data.
- `write`, `read`  out  1 each  slave strobes.
- `cs_ram`, `cs_gpu`, `cs_diodes`, `cs_led_counter`  out  1 each  chip selects.

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE**
  - If neither request is high, stay in IDLE.
  - Otherwise pick a winner by the arbitration rule (see Configuration).
  - Register the winner's `addr`, `we` and `wdata`, assert its `gnt`, load the wait counter with `WAIT_CYCLES`, and go to ACCESS.
- **ACCESS**
  - Drive `address_bus` and `wdata_bus`. Assert `write` if `we`=1, else `read`.
  - Assert exactly one chip select:
    - `cs_ram` when addr[15]=0.
    - `cs_diodes` when addr[15:12]=0x9.
    - `cs_led_counter` when addr[15:12]=0xA.
    - `cs_gpu` when addr[15:12]=0xF.
    - None for any other address (unmapped).
  - The counter decrements each cycle. At 0, capture `rdata_bus` (forced to 0 if unmapped) and go to DONE.
- **DONE**
  - Pulse the winner's `ack` for one cycle. `m_rdata` and `m_err` are valid in that cycle.
  - Strobes and chip selects are low.
  - If the winner's `lock` and `req` are both high, re-register its inputs and return to ACCESS; `gnt` stays high.
  - Otherwise drop `gnt` and go to IDLE.
- Requester rules:
  - Hold `addr`, `we` and `wdata` stable from `req` rise until `ack`.
  - Deassert `req` no later than the cycle after `ack`, unless another transfer is wanted.
  - A `req` still high in IDLE is a new transfer.
- Unmapped writes complete normally with `m_err`=1 and no strobe effect. `write` and `read` still pulse, but with no chip select asserted.
- Lock is honoured for at most 8 consecutive transfers. After the 8th, go to IDLE and arbitrate, so the other master cannot be starved.

## Timing
- Reset (asynchronous assert):
  - State IDLE, round-robin pointer at master 0, lock counter 0.
  - All outputs 0: gnt, ack, strobes, chip selects, buses, `m_rdata`, `m_err`.
- Reset asserted mid-ACCESS aborts the transfer with no ack.
- Deassertion is used directly; the board supplies a synchronised release.
- Latency (cycle 0 = edge where IDLE samples `req`):
  - Strobe and chip select high for cycles 1 … 1+`WAIT_CYCLES`.
  - Ack in cycle 2+`WAIT_CYCLES`.
  - Locked back-to-back: next strobe starts the cycle after ack, giving a period of `WAIT_CYCLES`+2.
- Strobes and chip selects are registered outputs, glitch-free, and never overlap between transfers.
- Both requests rising in the same cycle is resolved purely by the arbitration rule; `gnt` is one-hot or zero.

## Configuration
- `BUS_ARBITER_ROUND_ROBIN_EN` defined:
  - On contention, grant the master not granted last.
  - The pointer updates when a transfer completes.
- Undefined:
  - Fixed priority: master 0 (CPU) always wins contention.
  - The lock limit of 8 still applies.

## Test plan
- **Single read.** `WAIT_CYCLES`=1; M0 reads 0x0123 with `rdata_bus`=0xBEEF.
  - `cs_ram` and `read` high for cycles 1–2.
  - `m0_ack` in cycle 3 with `m_rdata`=0xBEEF and `m_err`=0.
- **Decode.** M1 writes 0x9000, 0xA004 and 0xF010 with data 0x55AA.
  - `cs_diodes`, `cs_led_counter` and `cs_gpu` fire respectively, each with `write`=1 and `wdata_bus`=0x55AA.
- **Unmapped read.** Read 0xC000.
  - No chip select; ack with `m_err`=1 and `m_rdata`=0.
- **Contention.** Both requests rise together, twice in a row.
  - Round-robin build: grant order M0, M1.
  - Fixed build: M0, M0.
- **Lock.** M1 holds `lock` and `req` for 10 transfers while M0 requests.
  - 8 consecutive M1 acks, then M0 is granted.
- **Reset mid-transfer.** Assert `reset` (low) in cycle 1 of ACCESS.
  - All outputs 0 immediately and no ack.
  - After release, a pending `req` restarts the transfer from IDLE.

Source files
------------

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// bus_arbiter : two-master arbiter + address decoder for the shared 16-bit bus
// Option macro: BUS_ARBITER_ROUND_ROBIN_EN (else fixed M0 priority). Rev 1.0
// ============================================================================
module bus_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m0_wdata,
  input  logic [15:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [15:0] m_rdata,
  output logic        m_err,
  output logic [15:0] address_bus,
  output logic [15:0] wdata_bus,
  input  logic [15:0] rdata_bus,
  output logic        write,
  output logic        read,
  output logic        cs_ram,
  output logic        cs_gpu,
  output logic        cs_diodes,
  output logic        cs_led_counter
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);
  localparam logic [2:0] LOCK_LAST = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  wait_cnt;
  logic [2:0]  lock_cnt;
  logic        owner;
  logic        unmapped;

  logic        pick;
  logic        sel;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        keep_lock;
  logic        load;
  logic        dec_ram;
  logic        dec_diodes;
  logic        dec_led;
  logic        dec_gpu;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  // rr_ptr names the master that wins the next contention
  logic rr_ptr;
  assign pick = m1_req && (!m0_req || rr_ptr);
`else
  assign pick = m1_req && !m0_req;
`endif

  // In IDLE the arbitration winner is loaded; in DONE the current owner reloads
  assign sel       = (state == IDLE) ? pick : owner;
  assign sel_addr  = sel ? m1_addr  : m0_addr;
  assign sel_wdata = sel ? m1_wdata : m0_wdata;
  assign sel_we    = sel ? m1_we    : m0_we;

  assign dec_ram    = !sel_addr[15];
  assign dec_diodes = (sel_addr[15:12] == 4'h9);
  assign dec_led    = (sel_addr[15:12] == 4'hA);
  assign dec_gpu    = (sel_addr[15:12] == 4'hF);

  assign keep_lock = (owner ? (m1_lock && m1_req) : (m0_lock && m0_req))
                     && (lock_cnt != LOCK_LAST);
  assign load = ((state == IDLE) && (m0_req || m1_req))
             || ((state == DONE) && keep_lock);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      wait_cnt       <= 3'd0;
      lock_cnt       <= 3'd0;
      owner          <= 1'b0;
      unmapped       <= 1'b0;
      m0_gnt         <= 1'b0;
      m1_gnt         <= 1'b0;
      m0_ack         <= 1'b0;
      m1_ack         <= 1'b0;
      m_rdata        <= 16'h0000;
      m_err          <= 1'b0;
      address_bus    <= 16'h0000;
      wdata_bus      <= 16'h0000;
      write          <= 1'b0;
      read           <= 1'b0;
      cs_ram         <= 1'b0;
      cs_gpu         <= 1'b0;
      cs_diodes      <= 1'b0;
      cs_led_counter <= 1'b0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      rr_ptr         <= 1'b0;
`endif
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;

      case (state)
        IDLE: begin
          if (load) begin
            lock_cnt <= 3'd0;
            state    <= ACCESS;
          end
        end

        ACCESS: begin
          if (wait_cnt == 3'd0) begin
            m_rdata        <= unmapped ? 16'h0000 : rdata_bus;
            m_err          <= unmapped;
            m0_ack         <= !owner;
            m1_ack         <= owner;
            write          <= 1'b0;
            read           <= 1'b0;
            cs_ram         <= 1'b0;
            cs_gpu         <= 1'b0;
            cs_diodes      <= 1'b0;
            cs_led_counter <= 1'b0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
            rr_ptr         <= !owner;
`endif
            state          <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        DONE: begin
          m_rdata <= 16'h0000;
          m_err   <= 1'b0;
          if (load) begin
            lock_cnt <= lock_cnt + 3'd1;
            state    <= ACCESS;
          end else begin
            m0_gnt <= 1'b0;
            m1_gnt <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      if (load) begin
        owner          <= sel;
        m0_gnt         <= !sel;
        m1_gnt         <= sel;
        address_bus    <= sel_addr;
        wdata_bus      <= sel_wdata;
        write          <= sel_we;
        read           <= !sel_we;
        cs_ram         <= dec_ram;
        cs_diodes      <= dec_diodes;
        cs_led_counter <= dec_led;
        cs_gpu         <= dec_gpu;
        unmapped       <= !(dec_ram || dec_diodes || dec_led || dec_gpu);
        wait_cnt       <= WAIT_INIT;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_bus_arbiter : directed self-checking bench for bus_arbiter (WAIT_CYCLES=1)
// Rev 1.0
// ============================================================================
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
  logic [15:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_ack, m1_ack;
  logic [15:0] m_rdata;
  logic        m_err;
  logic [15:0] address_bus, wdata_bus, rdata_bus;
  logic        write, read, cs_ram, cs_gpu, cs_diodes, cs_led_counter;

  int checks   = 0;
  int failures = 0;

  logic [3:0]  cs_vec;
  logic [58:0] all_out;
  assign cs_vec  = {cs_gpu, cs_led_counter, cs_diodes, cs_ram};
  assign all_out = {m0_gnt, m1_gnt, m0_ack, m1_ack, m_rdata, m_err,
                    address_bus, wdata_bus, write, read, cs_vec};

  bus_arbiter #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m_rdata(m_rdata), .m_err(m_err),
    .address_bus(address_bus), .wdata_bus(wdata_bus), .rdata_bus(rdata_bus),
    .write(write), .read(read),
    .cs_ram(cs_ram), .cs_gpu(cs_gpu), .cs_diodes(cs_diodes),
    .cs_led_counter(cs_led_counter)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    reset = 1'b1;
    step();
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL idle_after_reset: got %h expected 0", all_out);
    end
  endtask

  task automatic test_single_read();
    m0_addr = 16'h0123; m0_we = 1'b0; m0_req = 1'b1; rdata_bus = 16'hBEEF;
    for (int c = 1; c <= 2; c++) begin
      step();
      checks++;
      if ({m0_gnt, m1_gnt, m0_ack, read, write, cs_vec, address_bus} !==
          {5'b10010, 4'b0001, 16'h0123}) begin
        failures++;
        $display("FAIL read_strobe_c%0d: got %b %b %b %b %b %b %h expected 1 0 0 1 0 0001 0123",
                 c, m0_gnt, m1_gnt, m0_ack, read, write, cs_vec, address_bus);
      end
    end
    step();
    checks++;
    if ({m0_ack, m1_ack, m_err, m_rdata} !== {3'b100, 16'hBEEF}) begin
      failures++;
      $display("FAIL read_ack: got ack0=%b ack1=%b err=%b rdata=%h expected 1 0 0 beef",
               m0_ack, m1_ack, m_err, m_rdata);
    end
    checks++;
    if ({read, write, cs_vec} !== 6'b0) begin
      failures++; $display("FAIL read_strobe_off: got %b expected 000000", {read, write, cs_vec});
    end
    m0_req = 1'b0;
    step();
    checks++;
    if ({m0_gnt, m0_ack} !== 2'b00) begin
      failures++; $display("FAIL read_release: got gnt=%b ack=%b expected 0 0", m0_gnt, m0_ack);
    end
  endtask

  task automatic test_decode();
    logic [15:0] addrs [3];
    logic [3:0]  cse   [3];
    addrs = '{16'h9000, 16'hA004, 16'hF010};
    cse   = '{4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      m1_addr = addrs[i]; m1_wdata = 16'h55AA; m1_we = 1'b1; m1_req = 1'b1;
      rdata_bus = 16'h0000;
      for (int c = 1; c <= 2; c++) begin
        step();
        checks++;
        if ({m1_gnt, m0_gnt, write, read, cs_vec, wdata_bus, address_bus} !==
            {4'b1010, cse[i], 16'h55AA, addrs[i]}) begin
          failures++;
          $display("FAIL decode_%h_c%0d: got gnt=%b%b w=%b r=%b cs=%b wd=%h a=%h expected cs=%b wd=55aa",
                   addrs[i], c, m1_gnt, m0_gnt, write, read, cs_vec, wdata_bus, address_bus, cse[i]);
        end
      end
      step();
      checks++;
      if ({m1_ack, m0_ack, m_err, write, cs_vec} !== 8'b1000_0000) begin
        failures++;
        $display("FAIL decode_ack_%h: got ack1=%b ack0=%b err=%b w=%b cs=%b expected 1 0 0 0 0000",
                 addrs[i], m1_ack, m0_ack, m_err, write, cs_vec);
      end
      m1_req = 1'b0;
      step();
    end
  endtask

  task automatic test_unmapped();
    m0_addr = 16'hC000; m0_we = 1'b0; m0_req = 1'b1; rdata_bus = 16'h1234;
    step();
    checks++;
    if ({read, write, cs_vec} !== 6'b100000) begin
      failures++; $display("FAIL unmapped_strobe: got %b expected 100000", {read, write, cs_vec});
    end
    step();
    step();
    checks++;
    if ({m0_ack, m_err, m_rdata} !== {2'b11, 16'h0000}) begin
      failures++;
      $display("FAIL unmapped_ack: got ack=%b err=%b rdata=%h expected 1 1 0000", m0_ack, m_err, m_rdata);
    end
    m0_req = 1'b0;
    step();
  endtask

  task automatic test_contention();
    logic [1:0] exp_gnt [2];
    exp_gnt[0] = 2'b01;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    exp_gnt[1] = 2'b10;
`else
    exp_gnt[1] = 2'b01;
`endif
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      m0_addr = 16'h0010; m1_addr = 16'h0020; m0_we = 1'b0; m1_we = 1'b0;
      rdata_bus = 16'h0A0A; m0_req = 1'b1; m1_req = 1'b1;
      step();
      checks++;
      if ({m1_gnt, m0_gnt} !== exp_gnt[k]) begin
        failures++;
        $display("FAIL contention_gnt_%0d: got %b expected %b", k, {m1_gnt, m0_gnt}, exp_gnt[k]);
      end
      step();
      step();
      checks++;
      if ({m1_ack, m0_ack} !== exp_gnt[k]) begin
        failures++;
        $display("FAIL contention_ack_%0d: got %b expected %b", k, {m1_ack, m0_ack}, exp_gnt[k]);
      end
      m0_req = 1'b0; m1_req = 1'b0;
      step();
    end
  endtask

  task automatic test_lock();
    int ack_who [$];
    int ack_cyc [$];
    int n1 = 0;
    int onehot_bad = 0;
    m1_addr = 16'h0100; m1_we = 1'b0; m1_lock = 1'b1; m1_req = 1'b1;
    m0_addr = 16'h0200; m0_we = 1'b0; m0_req = 1'b0;
    rdata_bus = 16'h3C3C;
    for (int cyc = 1; cyc <= 100 && ack_who.size() < 11; cyc++) begin
      step();
      if (cyc == 1) m0_req = 1'b1;
      if (m0_gnt && m1_gnt) onehot_bad++;
      if (m0_ack) begin
        ack_who.push_back(0); ack_cyc.push_back(cyc); m0_req = 1'b0;
      end
      if (m1_ack) begin
        ack_who.push_back(1); ack_cyc.push_back(cyc); n1++;
        if (n1 == 10) begin m1_req = 1'b0; m1_lock = 1'b0; end
      end
    end
    checks++;
    if (ack_who.size() != 11) begin
      failures++; $display("FAIL lock_ack_count: got %0d expected 11", ack_who.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (ack_who[i] != ((i == 8) ? 0 : 1)) begin
          failures++;
          $display("FAIL lock_order_%0d: got master %0d expected master %0d", i, ack_who[i], (i == 8) ? 0 : 1);
        end
      end
      checks++;
      if (ack_cyc[0] != 3) begin
        failures++; $display("FAIL lock_first_ack: got cycle %0d expected 3", ack_cyc[0]);
      end
      for (int i = 1; i < 8; i++) begin
        checks++;
        if (ack_cyc[i] - ack_cyc[i-1] != 3) begin
          failures++;
          $display("FAIL lock_period_%0d: got %0d expected 3", i, ack_cyc[i] - ack_cyc[i-1]);
        end
      end
    end
    checks++;
    if (onehot_bad != 0) begin
      failures++; $display("FAIL gnt_onehot: got %0d overlaps expected 0", onehot_bad);
    end
    step();
    step();
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin
      failures++; $display("FAIL lock_release: got %b expected 00", {m0_gnt, m1_gnt});
    end
  endtask

  task automatic test_reset_mid();
    int ack_seen = 0;
    int nonzero  = 0;
    m0_addr = 16'h0040; m0_we = 1'b0; m0_req = 1'b1; rdata_bus = 16'h7777;
    step();
    checks++;
    if ({m0_gnt, read, cs_vec} !== 6'b110001) begin
      failures++; $display("FAIL mid_pre_reset: got %b expected 110001", {m0_gnt, read, cs_vec});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL mid_reset_outputs: got %h expected 0", all_out);
    end
    repeat (3) begin
      step();
      if (m0_ack || m1_ack) ack_seen++;
      if (all_out !== '0) nonzero++;
    end
    checks++;
    if (ack_seen != 0 || nonzero != 0) begin
      failures++; $display("FAIL mid_reset_hold: got acks=%0d nonzero=%0d expected 0 0", ack_seen, nonzero);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({m0_gnt, read, cs_vec, address_bus} !== {6'b110001, 16'h0040}) begin
      failures++;
      $display("FAIL mid_restart: got %b %h expected 110001 0040", {m0_gnt, read, cs_vec}, address_bus);
    end
    step();
    step();
    checks++;
    if ({m0_ack, m_rdata} !== {1'b1, 16'h7777}) begin
      failures++; $display("FAIL mid_restart_ack: got ack=%b rdata=%h expected 1 7777", m0_ack, m_rdata);
    end
    m0_req = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    m0_lock = 1'b0; m1_lock = 1'b0;
    m0_addr = 16'h0; m1_addr = 16'h0; m0_wdata = 16'h0; m1_wdata = 16'h0;
    rdata_bus = 16'h0;
    test_reset();
    test_single_read();
    test_decode();
    test_unmapped();
    test_contention();
    test_lock();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
